// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver: snapshots a packed BCD word on load and scans its
// digits one at a time, with leading-zero blanking and a sticky invalid-nibble flag.
module bcd_scan_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       bcd_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      bcd_err
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*DIGITS-1:0] snap_p0;
  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic [DIGITS:0]     nz_above;
  logic [3:0]          cur_nib;
  logic                cur_nz_above;
  logic                cur_blank;
  logic                bad_in;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  assign tick    = (pre == PRE_W'(SCAN_DIV - 1));
  assign an_next = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

  // nz_above[k] is set when any nibble from k up to the top is nonzero; invalid nibbles count as nonzero
  always_comb begin
    nz_above     = '0;
    cur_nib      = '0;
    cur_nz_above = 1'b0;
    bad_in       = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_above[k] = nz_above[k+1] | (snap_p0[4*k +: 4] != 4'd0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib      = snap_p0[4*k +: 4];
        cur_nz_above = nz_above[k];
      end
      if (bcd_in[4*k +: 4] > 4'd9) bad_in = 1'b1;
    end
    cur_blank = blank_lz && (idx != '0) && !cur_nz_above;
    seg_next  = polarity(cur_blank ? 7'h00 : decode(cur_nib));
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      snap_p0   <= '0;
      pre       <= '0;
      idx       <= '0;
      seg       <= polarity(7'h00);
      an        <= '0;
      digit_idx <= '0;
      bcd_err   <= 1'b0;
    end else begin
      // stage p0: snapshot capture, prescaler and scan index
      if (load) begin
        snap_p0 <= bcd_in;
        if (bad_in) bcd_err <= 1'b1;
      end
      if (tick) begin
        pre <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      // stage p1: registered display outputs for the current index
      an        <= an_next;
      digit_idx <= idx;
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: two configurations checked every cycle against an
// arithmetic reference model, plus table-driven scans and hand-written corner sequences.
module tb_bcd_scan_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, blank_lz;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a;
  logic [1:0]  an_b;
  logic [1:0]  idx_a;
  logic [0:0]  idx_b;
  logic        err_a, err_b;

  bcd_scan_display #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .RST(rst), .load(load), .bcd_in(bcd_a), .blank_lz(blank_lz),
    .seg(seg_a), .an(an_a), .digit_idx(idx_a), .bcd_err(err_a)
  );

  bcd_scan_display #(.DIGITS(2), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .RST(rst), .load(load), .bcd_in(bcd_b), .blank_lz(blank_lz),
    .seg(seg_b), .an(an_b), .digit_idx(idx_b), .bcd_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int nd [2] = '{4, 2};
  int sd [2] = '{4, 1};
  bit al [2] = '{1'b0, 1'b1};

  logic [15:0] snap_m [2];
  int          edge_m [2];
  bit          err_m  [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int d, input logic [15:0] s, input int k, input bit blz);
    logic [15:0] upper;
    logic [6:0]  r;
    upper = s >> (4 * k);
    r = dec[upper[3:0]];
    if (blz && k > 0 && upper == 16'h0) r = 7'h00;
    if (al[d]) r = ~r;
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) if (((v >> (4 * k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle to both DUTs, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit blz);
    logic [6:0]  es [2];
    logic [3:0]  ean [2];
    int          eidx [2];
    bit          eerr [2];
    logic [15:0] vm;
    rst = r; load = ld; bcd_a = v; bcd_b = v[7:0]; blank_lz = blz;
    for (int d = 0; d < 2; d++) begin
      vm = (d == 0) ? v : {8'h00, v[7:0]};
      if (r) begin
        es[d] = al[d] ? 7'h7F : 7'h00;
        ean[d] = '0; eidx[d] = 0; eerr[d] = 1'b0;
        snap_m[d] = '0; edge_m[d] = 0; err_m[d] = 1'b0;
      end else begin
        edge_m[d]++;
        eidx[d] = ((edge_m[d] - 1) / sd[d]) % nd[d];
        es[d]   = model_seg(d, snap_m[d], eidx[d], blz);
        ean[d]  = 4'b0001 << eidx[d];
        if (ld && has_bad(vm, nd[d])) err_m[d] = 1'b1;
        eerr[d] = err_m[d];
        if (ld) snap_m[d] = vm;
      end
    end
    @(posedge clk); #1;
    check("seg_a", seg_a, es[0]);
    check("an_a",  an_a,  ean[0]);
    check("idx_a", idx_a, eidx[0]);
    check("err_a", err_a, eerr[0]);
    check("seg_b", seg_b, es[1]);
    check("an_b",  an_b,  ean[1]);
    check("idx_b", idx_b, eidx[1]);
    check("err_b", err_b, eerr[1]);
  endtask

  typedef struct {
    logic [15:0] bcd;
    bit          blz;
    logic [6:0]  segs [4];
    bit          err;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] seen [4];
  bit found;
  logic [15:0] rv;

  initial begin
    vecs[0] = '{16'h1234, 1'b0, '{7'h66, 7'h4F, 7'h5B, 7'h06}, 1'b0};
    vecs[1] = '{16'h0070, 1'b1, '{7'h3F, 7'h07, 7'h00, 7'h00}, 1'b0};
    vecs[2] = '{16'h0070, 1'b0, '{7'h3F, 7'h07, 7'h3F, 7'h3F}, 1'b0};
    vecs[3] = '{16'h0000, 1'b1, '{7'h3F, 7'h00, 7'h00, 7'h00}, 1'b0};
    vecs[4] = '{16'h9805, 1'b1, '{7'h6D, 7'h3F, 7'h7F, 7'h6F}, 1'b0};
    vecs[5] = '{16'h00A5, 1'b1, '{7'h6D, 7'h40, 7'h00, 7'h00}, 1'b1};
    vecs[6] = '{16'h0005, 1'b0, '{7'h6D, 7'h3F, 7'h3F, 7'h3F}, 1'b1};

    // reset held two cycles
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    check("rst_seg_a", seg_a, 7'h00);
    check("rst_seg_b", seg_b, 7'h7F);
    check("rst_an_a", an_a, 4'b0000);

    // anode rotation, four cycles per digit
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 16'h0, 0);
      check("rot_an", an_a, 4'b0001 << (i / 4));
    end

    // table-driven full-scan captures
    for (int t = 0; t < 7; t++) begin
      step(0, 1, vecs[t].bcd, vecs[t].blz);
      for (int k = 0; k < 4; k++) seen[k] = 8'hFF;
      for (int j = 0; j < 18; j++) begin
        step(0, 0, 16'h0, vecs[t].blz);
        if (j >= 1) seen[idx_a] = {1'b0, seg_a};
      end
      for (int k = 0; k < 4; k++) check("tbl_digit", seen[k], {1'b0, vecs[t].segs[k]});
      check("tbl_err", err_a, vecs[t].err);
    end

    // sticky error only cleared by reset
    step(1, 0, 16'h0, 0);
    check("err_clear", err_a, 1'b0);

    // two-digit active-low instance: 8'h81 alternates 79 / 00
    step(0, 1, 16'h0081, 0);
    step(0, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h0, 0);
      check("b_alt", seg_b, (idx_b == 1'b1) ? 7'h00 : 7'h79);
    end

    // reset mid-scan with a simultaneous load
    step(1, 0, 16'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 16'h0, 0);
      if (idx_a == 2'd2) found = 1'b1;
    end
    check("mid_reach", found, 1'b1);
    step(1, 1, 16'h9999, 0);
    check("mid_an", an_a, 4'b0000);
    check("mid_idx", idx_a, 2'd0);
    step(0, 0, 16'h0, 0);
    check("mid_seg", seg_a, 7'h3F);
    check("mid_an1", an_a, 4'b0001);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rv = 16'($urandom());
      else begin
        rv = '0;
        for (int k = 0; k < 4; k++) rv[4*k +: 4] = 4'($urandom_range(0, 9));
        rv = rv >> (4 * $urandom_range(0, 3));
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, rv, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
